// File: rtl/eq_pkg.sv
// Shared equalizer definitions: Q2.14 gain format and the round/saturate helper
// used by the mixer and later output stages.
package eq_pkg;

    localparam int GAIN_FRAC  = 14;
    localparam int GAIN_UNITY = 16384;
    localparam int GAIN_W     = 16;

    typedef logic signed [GAIN_W-1:0] gain_t;

    // Round half toward +inf at bit 'frac', then clip into a signed 'wOut'-bit range.
    function automatic logic signed [63:0] sat_round(
        input  logic signed [63:0] value,
        input  int                 frac,
        input  int                 wOut,
        output logic               clipped
    );
        logic signed [63:0] rounded;
        logic signed [63:0] hiLim;
        logic signed [63:0] loLim;
        rounded = (value + (64'sd1 <<< (frac - 1))) >>> frac;
        hiLim   = (64'sd1 <<< (wOut - 1)) - 64'sd1;
        loLim   = -(64'sd1 <<< (wOut - 1));
        clipped = (rounded > hiLim) || (rounded < loLim);
        if (rounded > hiLim) return hiLim;
        if (rounded < loLim) return loLim;
        return rounded;
    endfunction

endpackage

// File: rtl/eq_gain_ramp.sv
// One band's gain: a written target plus a current value that slews toward it
// by at most GAIN_STEP per clock and lands on it exactly.
module eq_gain_ramp
    import eq_pkg::*;
#(
    parameter int WD_GAIN    = 16,
    parameter int GAIN_STEP  = 16,
    parameter int GAIN_RESET = GAIN_UNITY
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      we_i,
    input  logic signed [WD_GAIN-1:0] wdata_i,
    output logic signed [WD_GAIN-1:0] cur_o,
    output logic                      busy_o
);

    localparam logic signed [WD_GAIN:0]   STEP_W  = (WD_GAIN+1)'(GAIN_STEP);
    localparam logic signed [WD_GAIN-1:0] STEP_G  = WD_GAIN'(GAIN_STEP);
    localparam logic signed [WD_GAIN-1:0] RESET_G = WD_GAIN'(GAIN_RESET);

    logic signed [WD_GAIN-1:0] cur_q, cur_d;
    logic signed [WD_GAIN-1:0] tgt_q, tgt_d;
    logic signed [WD_GAIN:0]   diff;

    // The ramp chases the target held before this edge; a new write takes effect next edge.
    always_comb begin
        tgt_d = we_i ? wdata_i : tgt_q;
        diff  = (WD_GAIN+1)'(tgt_q) - (WD_GAIN+1)'(cur_q);
        if (diff > STEP_W)
            cur_d = cur_q + STEP_G;
        else if (diff < -STEP_W)
            cur_d = cur_q - STEP_G;
        else
            cur_d = tgt_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cur_q <= RESET_G;
            tgt_q <= RESET_G;
        end else begin
            cur_q <= cur_d;
            tgt_q <= tgt_d;
        end
    end

    assign cur_o  = cur_q;
    assign busy_o = (cur_q != tgt_q);

endmodule

// File: rtl/eq_band_mixer.sv
// Equalizer band mixer: per-band gain multiply, band sum, then round/saturate to
// one output sample per clock through a three-stage pipeline.
module eq_band_mixer
    import eq_pkg::*;
#(
    parameter int NUM_BANDS  = 4,
    parameter int WD_IN      = 24,
    parameter int WD_OUT     = 24,
    parameter int WD_GAIN    = 16,
    parameter int GAIN_STEP  = 16,
    parameter int GAIN_RESET = 16384
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_BANDS*WD_IN-1:0]   band_in,
    input  logic                         gain_we,
    input  logic [$clog2(NUM_BANDS)-1:0] gain_addr,
    input  logic [WD_GAIN-1:0]           gain_wdata,
    output logic                         gain_busy,
    output logic [WD_OUT-1:0]            data_out,
    output logic                         sat_flag
);

    localparam int AW      = $clog2(NUM_BANDS);
    localparam int WD_PROD = WD_IN + WD_GAIN;
    localparam int WD_ACC  = WD_PROD + AW;

    logic signed [WD_GAIN-1:0] curGain [NUM_BANDS];
    logic [NUM_BANDS-1:0]      bandBusy;
    logic signed [WD_PROD-1:0] prod_q [NUM_BANDS];
    logic signed [WD_ACC-1:0]  acc_q, acc_d;
    logic [WD_OUT-1:0]         data_q, data_d;
    logic                      sat_q, sat_d;

    // Addresses with no matching band decode to no write at all.
    for (genvar b = 0; b < NUM_BANDS; b++) begin : g_band
        eq_gain_ramp #(
            .WD_GAIN   (WD_GAIN),
            .GAIN_STEP (GAIN_STEP),
            .GAIN_RESET(GAIN_RESET)
        ) u_ramp (
            .clk    (clk),
            .reset_n(reset_n),
            .we_i   (gain_we && (gain_addr == AW'(b))),
            .wdata_i(gain_wdata),
            .cur_o  (curGain[b]),
            .busy_o (bandBusy[b])
        );
    end

    always_comb begin
        acc_d = '0;
        for (int b = 0; b < NUM_BANDS; b++)
            acc_d = acc_d + WD_ACC'(prod_q[b]);
    end

    always_comb begin
        sat_d  = 1'b0;
        data_d = WD_OUT'(sat_round(64'(acc_q), GAIN_FRAC, WD_OUT, sat_d));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int b = 0; b < NUM_BANDS; b++)
                prod_q[b] <= '0;
            acc_q  <= '0;
            data_q <= '0;
            sat_q  <= 1'b0;
        end else begin
            for (int b = 0; b < NUM_BANDS; b++)
                prod_q[b] <= WD_PROD'($signed(band_in[b*WD_IN +: WD_IN])) * WD_PROD'(curGain[b]);
            acc_q  <= acc_d;
            data_q <= data_d;
            sat_q  <= sat_d;
        end
    end

    assign gain_busy = |bandBusy;
    assign data_out  = data_q;
    assign sat_flag  = sat_q;

endmodule
